// File: rtl/reg_access_seq_pkg.sv
// Shared types for the register access sequencer.
// FSM state encodings and default geometry.
package reg_access_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SIZE  = 32;
    localparam int DEF_IDXW  = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/reg_access_seq_if.sv
// Request and execution handshakes of the sequencer.
// slave = sequencer side, master = decode/ALU side.
interface reg_access_seq_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [IDXW-1:0]  rs1;
    logic [IDXW-1:0]  rs2;
    logic [IDXW-1:0]  rd;
    logic             wb_en;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;

    modport slave (
        input  req_valid, rs1, rs2, rd, wb_en,
        input  res_valid, res_data,
        output req_ready, op_a, op_b, op_valid
    );

    modport master (
        output req_valid, rs1, rs2, rd, wb_en,
        output res_valid, res_data,
        input  req_ready, op_a, op_b, op_valid
    );

endinterface

// File: rtl/reg_access_seq_onehot_dec.sv
// Register index to one-hot select decoder.
// Out-of-range indices give an all-zero select.
module onehot_dec #(
    parameter int IDXW  = 5,
    parameter int WIDTH = 32,
    parameter int SIZE  = 32
) (
    input  logic             en,
    input  logic [IDXW-1:0]  idx,
    output logic             ok,
    output logic [WIDTH-1:0] sel
);

    assign ok = 32'(idx) < $unsigned(SIZE);

    // Set the single bit matching idx; bits at or above SIZE stay zero
    always_comb begin
        sel = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (en && idx == IDXW'(i)) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_access_seq.sv
// Sequencer for one register-to-register operation:
// read two operands, hand them to the ALU, write back.
import reg_access_seq_pkg::*;

module reg_access_seq #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE  = DEF_SIZE,
    parameter int IDXW  = DEF_IDXW
) (
    input  logic             clk,
    input  logic             reset,
    reg_access_seq_if.slave  ifc,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    output logic [WIDTH-1:0] selectR,
    output logic [WIDTH-1:0] selectR2,
    output logic [WIDTH-1:0] selectW,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_data,
    output logic             idx_err
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [IDXW-1:0]  rs1_q;
    logic [IDXW-1:0]  rs2_q;
    logic [IDXW-1:0]  rd_q;
    logic             wb_en_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] wr_data_q;
    logic             idx_err_q;
    logic             rs1_ok;
    logic             rs2_ok;
    logic             rd_ok;
    logic             do_wb;

    onehot_dec #(
        .IDXW  (IDXW),
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_dec_rs1 (
        .en  (state == S_READ),
        .idx (rs1_q),
        .ok  (rs1_ok),
        .sel (selectR)
    );

    onehot_dec #(
        .IDXW  (IDXW),
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_dec_rs2 (
        .en  (state == S_READ),
        .idx (rs2_q),
        .ok  (rs2_ok),
        .sel (selectR2)
    );

    onehot_dec #(
        .IDXW  (IDXW),
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_dec_rd (
        .en  (state == S_WRITE),
        .idx (rd_q),
        .ok  (rd_ok),
        .sel (selectW)
    );

    // r0 is never written and out-of-range rd skips the write port
    assign do_wb = wb_en_q && (rd_q != '0) && rd_ok;

    assign ifc.op_a = op_a_q;
    assign ifc.op_b = op_b_q;
    assign wr_data  = wr_data_q;
    assign idx_err  = idx_err_q;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (ifc.req_valid) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (ifc.res_valid) begin
                    state_nxt = do_wb ? S_WRITE : S_IDLE;
                end
            end
            S_WRITE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake and write-enable outputs decoded from state
    always_comb begin
        ifc.req_ready = 1'b0;
        ifc.op_valid  = 1'b0;
        wr_en         = 1'b0;
        unique case (state)
            S_IDLE:  ifc.req_ready = 1'b1;
            S_EXEC:  ifc.op_valid  = 1'b1;
            S_WRITE: wr_en         = 1'b1;
            default: ;
        endcase
    end

    // Request latch, operand capture, result capture and error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wb_en_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wr_data_q <= '0;
            idx_err_q <= 1'b0;
        end else begin
            if (state == S_IDLE && ifc.req_valid) begin
                rs1_q     <= ifc.rs1;
                rs2_q     <= ifc.rs2;
                rd_q      <= ifc.rd;
                wb_en_q   <= ifc.wb_en;
                idx_err_q <= 1'b0;
            end
            if (state == S_READ) begin
                op_a_q    <= rs1_ok ? bus_a : '0;
                op_b_q    <= rs2_ok ? bus_b : '0;
                idx_err_q <= !(rs1_ok && rs2_ok && rd_ok);
            end
            if (state == S_EXEC && ifc.res_valid) begin
                wr_data_q <= ifc.res_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_access_seq.sv
// Bench: register file model + sequencer + delayed adder ALU.
// Expected operands and writes are queued, a monitor checks them.
module tb_reg_access_seq;

    localparam int W = 32;
    localparam int S = 16;
    localparam int I = 5;

    typedef struct {
        logic [W-1:0] sel_r;
        logic [W-1:0] sel_r2;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_exp_t;

    typedef struct {
        logic [W-1:0] sel_w;
        logic [W-1:0] data;
    } wr_exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] bus_a;
    logic [W-1:0] bus_b;
    logic [W-1:0] selectR;
    logic [W-1:0] selectR2;
    logic [W-1:0] selectW;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         idx_err;

    logic [W-1:0] regs [S];
    logic         rf_clr;
    logic         pl_en;
    logic [3:0]   pl_idx;
    logic [W-1:0] pl_data;

    logic         alu_en;
    int           alu_cnt = 0;

    op_exp_t      op_q[$];
    wr_exp_t      wr_q[$];
    logic         op_valid_d = 1'b0;
    logic [W-1:0] sel_r_d = '0;
    logic [W-1:0] sel_r2_d = '0;

    int           checks = 0;
    int           errors = 0;

    reg_access_seq_if #(.WIDTH(W), .IDXW(I)) ifc ();

    reg_access_seq #(
        .WIDTH (W),
        .SIZE  (S),
        .IDXW  (I)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ifc      (ifc),
        .bus_a    (bus_a),
        .bus_b    (bus_b),
        .selectR  (selectR),
        .selectR2 (selectR2),
        .selectW  (selectW),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .idx_err  (idx_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Register file read ports: OR of selected registers
    always_comb begin
        bus_a = '0;
        bus_b = '0;
        for (int i = 0; i < S; i++) begin
            if (selectR[i])  bus_a |= regs[i];
            if (selectR2[i]) bus_b |= regs[i];
        end
    end

    // Register file write port, preload and clear; r0 stays zero
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < S; i++) regs[i] <= '0;
        end else if (pl_en) begin
            regs[pl_idx] <= pl_data;
        end else if (wr_en) begin
            for (int i = 1; i < S; i++) begin
                if (selectW[i]) regs[i] <= wr_data;
            end
        end
    end

    // ALU: result valid for one cycle, two cycles after operands appear
    always @(posedge clk) begin
        #1;
        if (!reset || ifc.res_valid) begin
            ifc.res_valid = 1'b0;
            alu_cnt = 0;
        end else if (ifc.op_valid && alu_en) begin
            alu_cnt++;
            if (alu_cnt == 2) begin
                ifc.res_valid = 1'b1;
                ifc.res_data  = ifc.op_a + ifc.op_b;
            end
        end
    end

    // Monitor: compare operand hand-off and write-backs against queues
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (ifc.op_valid && !op_valid_d) begin
                if (op_q.size() == 0) begin
                    chk("op_unexpected", 1, 0);
                end else begin
                    op_exp_t e;
                    e = op_q.pop_front();
                    chk("selectR", sel_r_d, e.sel_r);
                    chk("selectR2", sel_r2_d, e.sel_r2);
                    chk("op_a", ifc.op_a, e.a);
                    chk("op_b", ifc.op_b, e.b);
                end
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    chk("selectW", selectW, e.sel_w);
                    chk("wr_data", wr_data, e.data);
                end
            end
        end
        op_valid_d = ifc.op_valid;
        sel_r_d    = selectR;
        sel_r2_d   = selectR2;
    end

    task automatic preload(input logic [3:0] idx, input logic [W-1:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic send(input logic [I-1:0] a, input logic [I-1:0] b,
                        input logic [I-1:0] d, input logic wb);
        int n;
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.rs1       = a;
        ifc.rs2       = b;
        ifc.rd        = d;
        ifc.wb_en     = wb;
        n = 0;
        while (!ifc.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 1, 0);
        @(negedge clk);
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!ifc.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("res_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!ifc.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_op();
        int n;
        n = 0;
        while (!ifc.op_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("op_timeout", 1, 0);
    endtask

    initial begin
        reset         = 1'b0;
        rf_clr        = 1'b1;
        pl_en         = 1'b0;
        pl_idx        = '0;
        pl_data       = '0;
        alu_en        = 1'b1;
        ifc.req_valid = 1'b0;
        ifc.rs1       = '0;
        ifc.rs2       = '0;
        ifc.rd        = '0;
        ifc.wb_en     = 1'b0;

        // reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(ifc.req_ready), 1);
        chk("rst_selectR", selectR, 0);
        chk("rst_selectR2", selectR2, 0);
        chk("rst_selectW", selectW, 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_op_valid", 32'(ifc.op_valid), 0);
        chk("rst_idx_err", 32'(idx_err), 0);
        reset  = 1'b1;
        rf_clr = 1'b0;

        preload(4'd3, 32'd5);
        preload(4'd4, 32'd7);
        preload(4'd2, 32'd9);
        preload(4'd9, 32'h99);

        // r6 = r3 + r4
        op_q.push_back('{32'h8, 32'h10, 32'd5, 32'd7});
        wr_q.push_back('{32'h40, 32'd12});
        send(5'd3, 5'd4, 5'd6, 1'b1);
        wait_res();
        @(negedge clk);
        chk("t2_write_cycle", 32'(wr_en), 1);
        @(negedge clk);
        chk("t2_wr_en_one_cycle", 32'(wr_en), 0);
        chk("t2_ready_again", 32'(ifc.req_ready), 1);
        chk("t2_r6", regs[6], 32'd12);

        // rd = 0: no write, idle right after the result
        op_q.push_back('{32'h8, 32'h10, 32'd5, 32'd7});
        send(5'd3, 5'd4, 5'd0, 1'b1);
        wait_res();
        @(negedge clk);
        chk("t3_ready_after_res", 32'(ifc.req_ready), 1);
        chk("t3_no_wr_en", 32'(wr_en), 0);
        chk("t3_r0", regs[0], 0);

        // rs1 == rs2, r7 = r2 + r2
        op_q.push_back('{32'h4, 32'h4, 32'd9, 32'd9});
        wr_q.push_back('{32'h80, 32'd18});
        send(5'd2, 5'd2, 5'd7, 1'b1);
        wait_res();
        @(negedge clk);
        wait_idle();
        chk("t4_r7", regs[7], 32'd18);
        chk("t4_idx_err", 32'(idx_err), 0);

        // rs1 = 20 is beyond SIZE = 16
        op_q.push_back('{32'h0, 32'h10, 32'd0, 32'd7});
        send(5'd20, 5'd4, 5'd5, 1'b0);
        wait_idle();
        chk("t5_idx_err_rs1", 32'(idx_err), 1);
        chk("t5_r5", regs[5], 0);

        // rd = 18 beyond SIZE: write suppressed
        op_q.push_back('{32'h8, 32'h8, 32'd5, 32'd5});
        send(5'd3, 5'd3, 5'd18, 1'b1);
        wait_res();
        @(negedge clk);
        chk("t5_no_write_rd", 32'(wr_en), 0);
        chk("t5_idx_err_rd", 32'(idx_err), 1);

        // a valid request clears the flag
        op_q.push_back('{32'h8, 32'h10, 32'd5, 32'd7});
        send(5'd3, 5'd4, 5'd0, 1'b0);
        chk("t5_idx_err_cleared", 32'(idx_err), 0);
        wait_idle();
        chk("t5_idx_err_stays", 32'(idx_err), 0);

        // reset during EXEC aborts without a write
        alu_en = 1'b0;
        op_q.push_back('{32'h8, 32'h10, 32'd5, 32'd7});
        send(5'd3, 5'd4, 5'd9, 1'b1);
        wait_op();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_op_valid", 32'(ifc.op_valid), 0);
        chk("t6_req_ready", 32'(ifc.req_ready), 1);
        chk("t6_wr_en", 32'(wr_en), 0);
        reset  = 1'b1;
        alu_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_r9", regs[9], 32'h99);

        chk("op_queue_empty", 32'(op_q.size()), 0);
        chk("wr_queue_empty", 32'(wr_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
